// File: rtl/cr_xp10_decomp_sdd_wf_gen.sv
// Word feeder for the XP10 decompressor SDD path. Splits input beats into words,
// holds them, and repacks them into output beats, flushing at every block or frame end.
package cr_xp10_decomp_sdd_wf_gen_pkg;
    typedef enum logic [3:0] {
        NO_ERRORS      = 4'd0,
        CR_SDD_ERR     = 4'd1,
        CR_LFA_ERR     = 4'd2,
        CR_BHP_ERR     = 4'd3
    } zipline_error_e;
endpackage

module cr_xp10_decomp_sdd_wf_gen
    import cr_xp10_decomp_sdd_wf_gen_pkg::*;
#(
    parameter int IN_WORDS  = 2,
    parameter int OUT_WORDS = 4,
    parameter int WORD_BITS = 32,
    parameter int FBI_W     = 28
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [IN_WORDS*WORD_BITS-1:0]               in_data,
    input  logic [$clog2(IN_WORDS*WORD_BITS+1)-1:0]     in_numbits,
    input  logic                                        in_sob,
    input  logic                                        in_eob,
    input  logic                                        in_eof,
    input  logic                                        in_trace_bit,
    input  zipline_error_e                              in_errcode,
    input  logic [FBI_W-1:0]                            in_frame_bytes_in,
    input  logic                                        in_last_frame,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [OUT_WORDS*WORD_BITS-1:0]              out_data,
    output logic [$clog2(OUT_WORDS*WORD_BITS+1)-1:0]    out_numbits,
    output logic                                        out_sob,
    output logic                                        out_eob,
    output logic                                        out_eof,
    output logic                                        out_trace_bit,
    output logic                                        out_last_frame,
    output zipline_error_e                              out_errcode,
    output logic [FBI_W-1:0]                            out_frame_bytes_in,
    output logic [$clog2(OUT_WORDS+IN_WORDS+1)-1:0]     occupancy,
    output logic                                        input_stall_stb,
    output logic                                        protocol_err
);
    localparam int BUF_WORDS = OUT_WORDS + IN_WORDS;
    localparam int OCC_W     = $clog2(BUF_WORDS + 1);
    localparam int OUT_NB_W  = $clog2(OUT_WORDS * WORD_BITS + 1);
    localparam int WNB_W     = $clog2(WORD_BITS + 1);

    typedef struct packed {
        logic [WORD_BITS-1:0] data;
        logic [WNB_W-1:0]     numbits;
        logic                 sob;
        logic                 eob;
        logic                 eof;
        logic                 trace_bit;
        logic                 last_frame;
        logic                 last;
        zipline_error_e       errcode;
        logic [FBI_W-1:0]     frame_bytes_in;
    } word_t;

    word_t            buf_q [BUF_WORDS];
    word_t            buf_d [BUF_WORDS];
    word_t            in_words [IN_WORDS];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             last_held;
    logic             push;
    logic             fire;
    logic             end_mark;
    logic             perr_hit;
    int               occ_i;
    int               n_i;
    int               nb_i;
    int               in_count;
    int               last_bits;
    int               pop_cnt;
    int               surv;

    assign occ_i     = int'(occ_q);
    assign n_i       = (occ_i < OUT_WORDS) ? occ_i : OUT_WORDS;
    assign nb_i      = int'(in_numbits);
    assign end_mark  = in_eob || in_eof;
    assign occupancy = occ_q;

    always_comb begin
        last_held = 1'b0;
        for (int i = 0; i < BUF_WORDS; i++)
            if (i < occ_i && buf_q[i].last) last_held = 1'b1;
    end

    // Both handshakes depend only on registered state, so out_ready never reaches in_ready.
    assign in_ready  = (BUF_WORDS - occ_i >= IN_WORDS) && !last_held;
    assign out_valid = (occ_i >= OUT_WORDS) || (last_held && occ_i > 0);
    assign push      = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    assign perr_hit = push && ((nb_i > IN_WORDS * WORD_BITS) ||
                               (nb_i == 0 && !end_mark) ||
                               ((nb_i % WORD_BITS) != 0 && !end_mark) ||
                               (in_sob && occ_i > 0 && !last_held));

    // An oversized beat is clamped to IN_WORDS full words.
    always_comb begin
        in_count = (nb_i + WORD_BITS - 1) / WORD_BITS;
        if (in_count < 1) in_count = 1;
        if (in_count > IN_WORDS) in_count = IN_WORDS;
        last_bits = nb_i - (in_count - 1) * WORD_BITS;
        if (last_bits > WORD_BITS) last_bits = WORD_BITS;
        for (int j = 0; j < IN_WORDS; j++) begin
            in_words[j]                = '0;
            in_words[j].data           = in_data[j*WORD_BITS +: WORD_BITS];
            in_words[j].numbits        = WNB_W'((j < in_count - 1) ? WORD_BITS : last_bits);
            in_words[j].sob            = in_sob && (j == 0);
            in_words[j].trace_bit      = in_trace_bit;
            if (j == in_count - 1) begin
                in_words[j].eob            = in_eob;
                in_words[j].eof            = in_eof;
                in_words[j].last           = end_mark;
                in_words[j].last_frame     = in_last_frame;
                in_words[j].errcode        = in_errcode;
                in_words[j].frame_bytes_in = in_frame_bytes_in;
            end
        end
    end

    always_comb begin
        out_data           = '0;
        out_numbits        = '0;
        out_sob            = 1'b0;
        out_eob            = 1'b0;
        out_eof            = 1'b0;
        out_trace_bit      = 1'b0;
        out_last_frame     = 1'b0;
        out_errcode        = NO_ERRORS;
        out_frame_bytes_in = '0;
        for (int i = 0; i < OUT_WORDS; i++) begin
            if (i < n_i) out_data[i*WORD_BITS +: WORD_BITS] = buf_q[i].data;
            if (i == 0 && n_i > 0) begin
                out_sob       = buf_q[i].sob;
                out_trace_bit = buf_q[i].trace_bit;
            end
            if (i == n_i - 1) begin
                out_numbits        = OUT_NB_W'((n_i - 1) * WORD_BITS + int'(buf_q[i].numbits));
                out_eob            = buf_q[i].eob;
                out_eof            = buf_q[i].eof;
                out_last_frame     = buf_q[i].last_frame;
                out_errcode        = buf_q[i].errcode;
                out_frame_bytes_in = buf_q[i].frame_bytes_in;
            end
        end
    end

    // Survivors shift down by the pop count; new words land right after them.
    always_comb begin
        pop_cnt = fire ? n_i : 0;
        surv    = occ_i - pop_cnt;
        buf_d   = buf_q;
        for (int i = 0; i < BUF_WORDS; i++)
            for (int s = i + 1; s < BUF_WORDS; s++)
                if (s - i == pop_cnt) buf_d[i] = buf_q[s];
        if (push)
            for (int i = 0; i < BUF_WORDS; i++)
                for (int j = 0; j < IN_WORDS; j++)
                    if (j < in_count && i == surv + j) buf_d[i] = in_words[j];
        occ_d = OCC_W'(surv + (push ? in_count : 0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q           <= '0;
            input_stall_stb <= 1'b0;
            protocol_err    <= 1'b0;
        end else begin
            occ_q           <= occ_d;
            input_stall_stb <= in_valid && !in_ready && in_trace_bit;
            protocol_err    <= protocol_err || perr_hit;
        end
    end

    // NOTE: word storage has no reset; occupancy gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end
endmodule

// File: tb/tb_cr_xp10_decomp_sdd_wf_gen.sv
// Self-checking bench: a word-queue model of the feeder is compared with the DUT every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cr_xp10_decomp_sdd_wf_gen;
    import cr_xp10_decomp_sdd_wf_gen_pkg::*;

    localparam int IN   = 2;
    localparam int OUT  = 4;
    localparam int WB   = 32;
    localparam int FBI  = 28;
    localparam int BUFW = OUT + IN;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [63:0]    in_data;
    logic [6:0]     in_numbits;
    logic           in_sob, in_eob, in_eof, in_trace_bit, in_last_frame;
    zipline_error_e in_errcode;
    logic [FBI-1:0] in_frame_bytes_in;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic [7:0]     out_numbits;
    logic           out_sob, out_eob, out_eof, out_trace_bit, out_last_frame;
    zipline_error_e out_errcode;
    logic [FBI-1:0] out_frame_bytes_in;
    logic [2:0]     occupancy;
    logic           input_stall_stb;
    logic           protocol_err;

    cr_xp10_decomp_sdd_wf_gen #(
        .IN_WORDS(IN), .OUT_WORDS(OUT), .WORD_BITS(WB), .FBI_W(FBI)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_numbits(in_numbits),
        .in_sob(in_sob), .in_eob(in_eob), .in_eof(in_eof), .in_trace_bit(in_trace_bit),
        .in_errcode(in_errcode), .in_frame_bytes_in(in_frame_bytes_in), .in_last_frame(in_last_frame),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_numbits(out_numbits),
        .out_sob(out_sob), .out_eob(out_eob), .out_eof(out_eof), .out_trace_bit(out_trace_bit),
        .out_last_frame(out_last_frame), .out_errcode(out_errcode),
        .out_frame_bytes_in(out_frame_bytes_in), .occupancy(occupancy),
        .input_stall_stb(input_stall_stb), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]    data;
        int             nb;
        bit             sob, eob, eof, tr, lf, last;
        zipline_error_e err;
        logic [FBI-1:0] fbi;
    } mw_t;

    typedef struct {
        logic [127:0] data;
        int           nb;
        bit           sob, eob, eof;
    } cap_t;

    mw_t  q[$];
    cap_t caps[$];
    bit   exp_perr;
    bit   exp_stall;
    int   n_cmp;
    int   n_mis;
    int   cyc;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_last_held();
        foreach (q[i]) if (q[i].last) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_in_ready();
        return (BUFW - q.size() >= IN) && !m_last_held();
    endfunction

    function automatic bit m_out_valid();
        return (q.size() >= OUT) || (m_last_held() && q.size() > 0);
    endfunction

    task automatic model_update();
        bit  rdy, ov, acc, fire, endm;
        int  n, nb, k;
        mw_t w;
        if (!rst_n) begin
            q.delete();
            exp_perr  = 1'b0;
            exp_stall = 1'b0;
            return;
        end
        rdy  = m_in_ready();
        ov   = m_out_valid();
        acc  = in_valid && rdy;
        fire = ov && out_ready;
        n    = (q.size() < OUT) ? q.size() : OUT;
        exp_stall = in_valid && !rdy && in_trace_bit;
        endm = in_eob || in_eof;
        nb   = int'(in_numbits);
        if (acc) begin
            if (nb > IN * WB) exp_perr = 1'b1;
            if (nb == 0 && !endm) exp_perr = 1'b1;
            if (nb % WB != 0 && !endm) exp_perr = 1'b1;
            if (in_sob && q.size() > 0 && !m_last_held()) exp_perr = 1'b1;
        end
        if (fire) repeat (n) void'(q.pop_front());
        if (acc) begin
            k = (nb + WB - 1) / WB;
            if (k < 1) k = 1;
            if (k > IN) k = IN;
            for (int j = 0; j < k; j++) begin
                w.data = in_data[j*WB +: WB];
                w.nb   = (j < k - 1) ? WB : ((nb - (k - 1) * WB > WB) ? WB : nb - (k - 1) * WB);
                w.sob  = in_sob && j == 0;
                w.tr   = in_trace_bit;
                w.last = (j == k - 1) && endm;
                w.eob  = (j == k - 1) && in_eob;
                w.eof  = (j == k - 1) && in_eof;
                w.lf   = (j == k - 1) && in_last_frame;
                w.err  = (j == k - 1) ? in_errcode : NO_ERRORS;
                w.fbi  = (j == k - 1) ? in_frame_bytes_in : '0;
                q.push_back(w);
            end
        end
    endtask

    task automatic compare();
        logic [127:0] ed;
        int           en;
        check("in_ready", 256'(in_ready), 256'(m_in_ready()));
        check("out_valid", 256'(out_valid), 256'(m_out_valid()));
        check("occupancy", 256'(occupancy), 256'(q.size()));
        check("input_stall_stb", 256'(input_stall_stb), 256'(exp_stall));
        check("protocol_err", 256'(protocol_err), 256'(exp_perr));
        if (m_out_valid()) begin
            en = (q.size() < OUT) ? q.size() : OUT;
            ed = '0;
            for (int i = 0; i < en; i++) ed[i*WB +: WB] = q[i].data;
            check("out_data", 256'(out_data), 256'(ed));
            check("out_numbits", 256'(out_numbits), 256'((en - 1) * WB + q[en-1].nb));
            check("out_sob", 256'(out_sob), 256'(q[0].sob));
            check("out_trace_bit", 256'(out_trace_bit), 256'(q[0].tr));
            check("out_eob", 256'(out_eob), 256'(q[en-1].eob));
            check("out_eof", 256'(out_eof), 256'(q[en-1].eof));
            check("out_last_frame", 256'(out_last_frame), 256'(q[en-1].lf));
            check("out_errcode", 256'(out_errcode), 256'(q[en-1].err));
            check("out_frame_bytes_in", 256'(out_frame_bytes_in), 256'(q[en-1].fbi));
        end
    endtask

    // Called at a falling edge with inputs already driven for the next rising edge.
    task automatic step();
        cap_t c;
        if (out_valid && out_ready) begin
            c.data = out_data;
            c.nb   = int'(out_numbits);
            c.sob  = out_sob;
            c.eob  = out_eob;
            c.eof  = out_eof;
            caps.push_back(c);
        end
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic send_beat(input logic [63:0] d, input int nb, input bit sob, input bit eob,
                             input bit eof, input bit tr);
        bit done;
        int waited;
        done              = 1'b0;
        waited            = 0;
        in_data           = d;
        in_numbits        = 7'(nb);
        in_sob            = sob;
        in_eob            = eob;
        in_eof            = eof;
        in_trace_bit      = tr;
        in_errcode        = zipline_error_e'($urandom_range(0, 3));
        in_frame_bytes_in = FBI'($urandom);
        in_last_frame     = 1'($urandom);
        in_valid          = 1'b1;
        while (!done) begin
            done = m_in_ready();
            step();
            waited++;
            if (!done && waited > 50) begin
                n_cmp++;
                n_mis++;
                $display("FAIL accept_timeout: beat not accepted within 50 cycles (cycle %0d)", cyc);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        bit  endm;
        int  nb;
        n_cmp = 0; n_mis = 0; cyc = 0;
        exp_perr = 1'b0; exp_stall = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_numbits = '0; in_sob = 0; in_eob = 0; in_eof = 0;
        in_trace_bit = 0; in_errcode = NO_ERRORS; in_frame_bytes_in = '0; in_last_frame = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_occupancy", 256'(occupancy), 256'(0));
        check("rst_protocol_err", 256'(protocol_err), 256'(0));
        check("rst_stall", 256'(input_stall_stb), 256'(0));

        // Four 64-bit beats, eob on the last: two full 128-bit outputs.
        out_ready = 1'b1;
        caps.delete();
        t0 = cyc;
        send_beat(64'h22222222_00000001, 64, 1, 0, 0, 0);
        send_beat(64'h22222222_00000002, 64, 0, 0, 0, 0);
        send_beat(64'h44444444_00000003, 64, 0, 0, 0, 0);
        send_beat(64'h44444444_00000004, 64, 0, 1, 0, 0);
        check("t1_no_input_bubbles", 256'(cyc - t0), 256'(4));
        idle(4);
        check("t1_out_count", 256'(caps.size()), 256'(2));
        if (caps.size() == 2) begin
            check("t1_o0_numbits", 256'(caps[0].nb), 256'(128));
            check("t1_o0_sob", 256'(caps[0].sob), 256'(1));
            check("t1_o0_eob", 256'(caps[0].eob), 256'(0));
            check("t1_o0_data", 256'(caps[0].data), 256'(128'h22222222_00000002_22222222_00000001));
            check("t1_o1_numbits", 256'(caps[1].nb), 256'(128));
            check("t1_o1_eob", 256'(caps[1].eob), 256'(1));
            check("t1_o1_data", 256'(caps[1].data), 256'(128'h44444444_00000004_44444444_00000003));
        end

        // Single 40-bit beat: two words, upper half of the output zero.
        caps.delete();
        send_beat(64'h000000EE_12345678, 40, 1, 1, 0, 0);
        idle(3);
        check("t2_out_count", 256'(caps.size()), 256'(1));
        if (caps.size() == 1) begin
            check("t2_numbits", 256'(caps[0].nb), 256'(40));
            check("t2_sob", 256'(caps[0].sob), 256'(1));
            check("t2_eob", 256'(caps[0].eob), 256'(1));
            check("t2_data", 256'(caps[0].data), 256'(128'h000000EE_12345678));
        end

        // A 64-bit block end followed by an empty frame-end beat gives two separate outputs.
        caps.delete();
        send_beat(64'h0BADF00D_CAFEBABE, 64, 1, 1, 0, 0);
        send_beat(64'h0, 0, 0, 0, 1, 0);
        idle(3);
        check("t3_out_count", 256'(caps.size()), 256'(2));
        if (caps.size() == 2) begin
            check("t3_o0_numbits", 256'(caps[0].nb), 256'(64));
            check("t3_o0_eof", 256'(caps[0].eof), 256'(0));
            check("t3_o1_numbits", 256'(caps[1].nb), 256'(0));
            check("t3_o1_eof", 256'(caps[1].eof), 256'(1));
        end
        check("t3_protocol_err", 256'(protocol_err), 256'(0));

        // Back-pressure with trace bits set: buffer fills, input stalls, strobe follows.
        out_ready = 1'b0;
        send_beat(64'h11111111_AAAAAAAA, 64, 1, 0, 0, 1);
        send_beat(64'h22222222_BBBBBBBB, 64, 0, 0, 0, 1);
        send_beat(64'h33333333_CCCCCCCC, 64, 0, 0, 0, 1);
        check("t4_occupancy", 256'(occupancy), 256'(6));
        check("t4_in_ready", 256'(in_ready), 256'(0));
        in_valid = 1'b1;
        in_numbits = 7'd64;
        in_sob = 0; in_eob = 0; in_eof = 0; in_trace_bit = 1'b1;
        step();
        step();
        check("t4_stall_stb", 256'(input_stall_stb), 256'(1));
        check("t4_held_data", 256'(out_data), 256'(128'h22222222_BBBBBBBB_11111111_AAAAAAAA));
        in_valid = 1'b0;
        step();
        check("t4_stall_stb_clear", 256'(input_stall_stb), 256'(0));
        out_ready = 1'b1;
        send_beat(64'h0, 0, 0, 1, 0, 1);
        idle(3);
        check("t4_drained", 256'(occupancy), 256'(0));

        // Randomized traffic with legal beats.
        for (int i = 0; i < 400; i++) begin
            endm = ($urandom_range(0, 3) == 0);
            nb   = endm ? int'($urandom_range(0, 64)) : 32 * int'($urandom_range(1, 2));
            in_valid          = ($urandom_range(0, 9) < 7);
            out_ready         = ($urandom_range(0, 9) < 6);
            in_data           = {$urandom, $urandom};
            in_numbits        = 7'(nb);
            in_eob            = endm && ($urandom_range(0, 2) != 0);
            in_eof            = endm && !in_eob ? 1'b1 : (endm && 1'($urandom));
            in_sob            = (q.size() == 0 || m_last_held()) ? 1'($urandom) : 1'b0;
            in_trace_bit      = 1'($urandom);
            in_errcode        = zipline_error_e'($urandom_range(0, 3));
            in_frame_bytes_in = FBI'($urandom);
            in_last_frame     = 1'($urandom);
            step();
        end
        out_ready = 1'b1;
        send_beat(64'h0, 0, 0, 1, 0, 0);
        idle(6);
        check("rand_drained", 256'(occupancy), 256'(0));

        // Oversized beat: accepted as two words, error is sticky.
        send_beat({$urandom, $urandom}, 72, 1, 0, 0, 0);
        check("t5_protocol_err", 256'(protocol_err), 256'(1));
        check("t5_occupancy", 256'(occupancy), 256'(2));
        idle(2);
        check("t5_protocol_err_sticky", 256'(protocol_err), 256'(1));

        // Reset with five words buffered discards them immediately.
        out_ready = 1'b0;
        send_beat(64'h55555555_66666666, 64, 0, 0, 0, 0);
        send_beat(64'h0, 32, 0, 0, 0, 0);
        check("t6_occupancy_pre", 256'(occupancy), 256'(5));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_occupancy", 256'(occupancy), 256'(0));
        check("t6_rst_out_valid", 256'(out_valid), 256'(0));
        check("t6_rst_protocol_err", 256'(protocol_err), 256'(0));
        check("t6_rst_in_ready", 256'(in_ready), 256'(1));
        q.delete();
        exp_perr  = 1'b0;
        exp_stall = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        caps.delete();
        send_beat(64'hA5A5A5A5_5A5A5A5A, 64, 1, 0, 0, 0);
        send_beat(64'hC3C3C3C3_3C3C3C3C, 64, 0, 1, 0, 0);
        idle(3);
        check("t6_out_count", 256'(caps.size()), 256'(1));
        if (caps.size() == 1) begin
            check("t6_numbits", 256'(caps[0].nb), 256'(128));
            check("t6_sob", 256'(caps[0].sob), 256'(1));
            check("t6_eob", 256'(caps[0].eob), 256'(1));
            check("t6_data", 256'(caps[0].data), 256'(128'hC3C3C3C3_3C3C3C3C_A5A5A5A5_5A5A5A5A));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
